// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the in-order pipeline, with a watchdogged multi-cycle unit handshake.
// Optional stall-cycle counter enabled by defining HAZARD_PERFCNT_EN.
module pipe_hazard_ctrl #(
   parameter int STAGES     = 5,
   parameter int MC_STAGE   = 2,
   parameter int MC_TIMEOUT = 8,
   parameter int CNT_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [STAGES-1:0] StallReq,
   input  logic [STAGES-1:0] FlushReq,
   input  logic              McStart,
   input  logic              McDone,
   output logic [STAGES-1:0] En,
   output logic [STAGES-1:0] Flush,
   output logic              McBusy,
   output logic              Timeout,
   output logic [31:0]       StallCycles
);

   typedef enum logic [1:0] {IDLE, BUSY, TMO} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               mc_hold;
   logic [STAGES-1:0]  stall_eff, stalled, flush_older, flush_c;
   logic               sacc, facc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: if (McStart && !McDone) begin
            state_n = BUSY;
            cnt_n   = '0;
         end
         // Done takes precedence over the watchdog limit
         BUSY: if (McDone)                               state_n = IDLE;
               else if (cnt == CNT_W'(MC_TIMEOUT - 1))   state_n = TMO;
               else                                      cnt_n   = cnt + 1'b1;
         TMO: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_comb begin
      mc_hold   = (state == BUSY) && !McDone;
      stall_eff = StallReq | ({{(STAGES-1){1'b0}}, mc_hold} << MC_STAGE);
      sacc = 1'b0;
      facc = 1'b0;
      for (int i = STAGES-1; i >= 0; i--) begin
         sacc           = sacc | stall_eff[i];
         stalled[i]     = sacc;
         flush_older[i] = facc;
         facc           = facc | FlushReq[i];
      end
      flush_c = flush_older | {STAGES{state == TMO}};
      // Bubble goes into the first moving stage just past a stall boundary
      for (int i = 1; i < STAGES; i++)
         if (stalled[i-1] && !stalled[i]) flush_c[i] = 1'b1;
   end

   always_comb begin
      En      = reset ? '0 : ~stalled;
      Flush   = reset ? '1 : flush_c;
      McBusy  = (state == BUSY);
      Timeout = (state == TMO);
   end

`ifdef HAZARD_PERFCNT_EN
   logic [31:0] sc;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   sc <= '0;
      else if (!En[0] && sc != '1) sc <= sc + 32'd1;
   end
   assign StallCycles = sc;
`else
   assign StallCycles = 32'h0;
`endif

endmodule
